// File: rtl/rr_arb4way16_if.sv
// Handshake bundle between four producer channels, the round-robin arbiter and its consumer.
interface rr_arb4way16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             a_valid;
  logic             b_valid;
  logic             c_valid;
  logic             d_valid;
  logic             a_ready;
  logic             b_ready;
  logic             c_ready;
  logic             d_ready;
  logic [WIDTH-1:0] out;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  a, b, c, d, a_valid, b_valid, c_valid, d_valid, out_ready,
    output a_ready, b_ready, c_ready, d_ready, out, sel, out_valid
  );

  modport master (
    output a, b, c, d, a_valid, b_valid, c_valid, d_valid, out_ready,
    input  a_ready, b_ready, c_ready, d_ready, out, sel, out_valid
  );
endinterface

// File: rtl/rr_arb4way16.sv
// Four-channel round-robin arbiter with a one-word registered output stage.
// Optional feature macro: ARB_LOCK_EN adds the lock input that pins the grant to the last winner.
module rr_arb4way16 #(
  parameter int         WIDTH     = 16,
  parameter logic [1:0] RESET_PTR = 2'd3
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ARB_LOCK_EN
  input  logic              lock,
`endif
  rr_arb4way16_if.slave     bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] out_r;
  logic [1:0]       sel_r;
  logic [1:0]       ptr_r;
  logic [3:0]       valid_vec_s;
  logic [2:0]       pick_s;
  logic             load_s;
  logic             grant_s;
  logic [1:0]       gidx_s;
  logic [3:0]       ready_vec_s;
  logic [WIDTH-1:0] data_s;

  // Scan p+1, p+2, p+3, p (mod 4); returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = p + 2'(i);
      if (!r[2] && v[idx]) begin
        r = {1'b1, idx};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign valid_vec_s = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};

  // Grant selection, combinational readies and next-state logic.
  always_comb begin
    load_s      = 1'b0;
    pick_s      = 3'b000;
    grant_s     = 1'b0;
    gidx_s      = 2'd0;
    ready_vec_s = 4'b0000;
    data_s      = {WIDTH{1'b0}};
    state_s     = state_r;

    case (state_r)
      EMPTY:   load_s = 1'b1;
      FULL:    load_s = bus.out_ready;
      default: load_s = 1'b0;
    endcase

`ifdef ARB_LOCK_EN
    if (lock) begin
      pick_s = {valid_vec_s[ptr_r], ptr_r};
    end else begin
      pick_s = rr_pick(valid_vec_s, ptr_r);
    end
`else
    pick_s = rr_pick(valid_vec_s, ptr_r);
`endif

    // Gating with rst_n keeps every ready low while reset is asserted.
    grant_s = load_s & pick_s[2] & rst_n;
    gidx_s  = pick_s[1:0];

    if (grant_s) begin
      ready_vec_s = 4'b0001 << gidx_s;
    end else begin
      ready_vec_s = 4'b0000;
    end

    case (gidx_s)
      2'd0:    data_s = bus.a;
      2'd1:    data_s = bus.b;
      2'd2:    data_s = bus.c;
      2'd3:    data_s = bus.d;
      default: data_s = {WIDTH{1'b0}};
    endcase

    if (load_s) begin
      state_s = grant_s ? FULL : EMPTY;
    end else begin
      state_s = state_r;
    end
  end

  // State, output word, source index and last-grant pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      out_r   <= {WIDTH{1'b0}};
      sel_r   <= 2'd0;
      ptr_r   <= RESET_PTR;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        out_r <= data_s;
        sel_r <= gidx_s;
        ptr_r <= gidx_s;
      end else begin
        out_r <= out_r;
        sel_r <= sel_r;
        ptr_r <= ptr_r;
      end
    end
  end

  assign bus.a_ready   = ready_vec_s[0];
  assign bus.b_ready   = ready_vec_s[1];
  assign bus.c_ready   = ready_vec_s[2];
  assign bus.d_ready   = ready_vec_s[3];
  assign bus.out       = out_r;
  assign bus.sel       = sel_r;
  assign bus.out_valid = (state_r == FULL);

endmodule

// File: tb/tb_rr_arb4way16.sv
// Directed self-checking bench for rr_arb4way16 (lock scenario built only with ARB_LOCK_EN).
module tb_rr_arb4way16;

  logic clk;
  logic rst_n;
  logic lock;
  int   total;
  int   bad;

  rr_arb4way16_if #(.WIDTH(16)) bus ();

  rr_arb4way16 #(.WIDTH(16), .RESET_PTR(2'd3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] readies();
    return {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
  endfunction

  task automatic set_valids(input logic [3:0] v);
    {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid} = v;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    lock = 1'b0;
    bus.a = 16'h1234; bus.b = 16'h9876; bus.c = 16'hAAAA; bus.d = 16'h5555;
    set_valids(4'b0000);
    bus.out_ready = 1'b0;
    #2;
    total++; if (bus.out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h exp=0000", bus.out); end
    total++; if (bus.sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", bus.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.c_valid = 1'b1;
    #1;
    total++; if (readies() !== 4'b0100) begin bad++; $display("FAIL pre_c_ready got=%b exp=0100", readies()); end
    tick();
    total++; if (bus.out !== 16'hAAAA || bus.out_valid !== 1'b1) begin bad++; $display("FAIL pre_c_load got=%h/%b exp=aaaa/1", bus.out, bus.out_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out !== 16'h0000 || bus.sel !== 2'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL midcycle_reset got=%h/%0d/%b exp=0000/0/0", bus.out, bus.sel, bus.out_valid); end
    total++; if (readies() !== 4'b0000) begin bad++; $display("FAIL reset_readies got=%b exp=0000", readies()); end
    bus.c_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // After reset ptr=3, so a goes first; the run ends holding c.
  task automatic test_round_robin;
    logic [15:0] words [4];
    words[0] = 16'h1234; words[1] = 16'h9876; words[2] = 16'hAAAA; words[3] = 16'h5555;
    set_valids(4'b1111);
    bus.out_ready = 1'b1;
    #1;
    total++; if (readies() !== 4'b0001) begin bad++; $display("FAIL rr_first_ready got=%b exp=0001", readies()); end
    for (int k = 0; k < 7; k++) begin
      tick();
      total++;
      if (bus.sel !== 2'(k % 4) || bus.out !== words[k % 4] || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL rr_step%0d got=%0d/%h exp=%0d/%h", k, bus.sel, bus.out, k % 4, words[k % 4]);
      end
    end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    #1;
    total++; if (readies() !== 4'b0000) begin bad++; $display("FAIL bp_readies got=%b exp=0000", readies()); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.out !== 16'hAAAA || bus.sel !== 2'd2 || bus.out_valid !== 1'b1 || readies() !== 4'b0000) begin
        bad++; $display("FAIL bp_hold%0d got=%h/%0d/%b/%b exp=aaaa/2/1/0000", k, bus.out, bus.sel, bus.out_valid, readies());
      end
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (readies() !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b exp=1000", readies()); end
    tick();
    total++; if (bus.sel !== 2'd3 || bus.out !== 16'h5555) begin bad++; $display("FAIL bp_release got=%0d/%h exp=3/5555", bus.sel, bus.out); end
  endtask

  task automatic test_drain;
    set_valids(4'b0000);
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out !== 16'h5555 || bus.sel !== 2'd3) begin
      bad++; $display("FAIL drain got=%b/%h/%0d exp=0/5555/3", bus.out_valid, bus.out, bus.sel); end
    set_valids(4'b0011);
    #1;
    total++; if (readies() !== 4'b0001) begin bad++; $display("FAIL drain_a_ready got=%b exp=0001", readies()); end
    tick();
    total++; if (bus.sel !== 2'd0 || bus.out !== 16'h1234 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL drain_a got=%0d/%h exp=0/1234", bus.sel, bus.out); end
    set_valids(4'b0000);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_single;
    bus.b_valid = 1'b1;
    #1;
    total++; if (readies() !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=0010", readies()); end
    tick();
    bus.b_valid = 1'b0;
    total++; if (bus.out !== 16'h9876 || bus.sel !== 2'd1 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL single_out got=%h/%0d/%b exp=9876/1/1", bus.out, bus.sel, bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", bus.out_valid); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock;
    bus.c_valid = 1'b1;
    tick();
    total++; if (bus.sel !== 2'd2 || bus.out !== 16'hAAAA) begin bad++; $display("FAIL lock_pre got=%0d/%h exp=2/aaaa", bus.sel, bus.out); end
    set_valids(4'b1011);
    lock = 1'b1;
    #1;
    total++; if (readies() !== 4'b0000) begin bad++; $display("FAIL lock_block got=%b exp=0000", readies()); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lock_drain got=%b exp=0", bus.out_valid); end
    bus.c_valid = 1'b1;
    #1;
    total++; if (readies() !== 4'b0100) begin bad++; $display("FAIL lock_c_ready got=%b exp=0100", readies()); end
    tick();
    total++; if (bus.sel !== 2'd2 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL lock_regrant got=%0d/%b exp=2/1", bus.sel, bus.out_valid); end
    lock = 1'b0;
    set_valids(4'b0000);
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_single();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
